// File: rtl/issue_select_ctrl.sv
// Oldest-first issue select: an age matrix orders the slots, and each ready port
// takes the next-oldest requesting slot in the same cycle.
module issue_select_ctrl #(
    parameter int NUM_SLOTS   = 8,
    parameter int ISSUE_WIDTH = 2,
    parameter int IDX_W       = $clog2(NUM_SLOTS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alloc_valid,
    input  logic [IDX_W-1:0]             alloc_idx,
    input  logic [NUM_SLOTS-1:0]         slot_request,
    input  logic [ISSUE_WIDTH-1:0]       port_ready,
    input  logic                         flush,
    output logic [NUM_SLOTS-1:0]         slot_grant,
    output logic [ISSUE_WIDTH-1:0]       port_valid,
    output logic [ISSUE_WIDTH*IDX_W-1:0] port_slot_idx,
    output logic [$clog2(ISSUE_WIDTH+1)-1:0] grant_count
);

    localparam int CNT_W  = $clog2(ISSUE_WIDTH + 1);
    localparam int RANK_W = IDX_W + 1;

    logic [NUM_SLOTS-1:0] older      [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] older_next [NUM_SLOTS];
    logic [RANK_W-1:0]    rank       [NUM_SLOTS];
    logic [CNT_W-1:0]     ready_rank [ISSUE_WIDTH];
    logic [NUM_SLOTS-1:0] grant_int;
    logic [ISSUE_WIDTH-1:0] valid_int;
    logic [ISSUE_WIDTH*IDX_W-1:0] idx_int;

    // Allocation overrides the flush clear, so a slot allocated during a flush
    // ends up youngest relative to everything.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            older_next[i] = '0;
            for (int j = 0; j < NUM_SLOTS; j++) begin
                if (i == j) begin
                    older_next[i][j] = 1'b0;
                end else if (alloc_valid && (alloc_idx == IDX_W'(i))) begin
                    older_next[i][j] = 1'b0;
                end else if (alloc_valid && (alloc_idx == IDX_W'(j))) begin
                    older_next[i][j] = 1'b1;
                end else if (flush) begin
                    older_next[i][j] = 1'b0;
                end else begin
                    older_next[i][j] = older[i][j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                older[i] <= older_next[i];
            end
        end
    end

    // Rank = number of requesting slots that beat this one; equal age falls
    // back to index order, so the ranks of requesters are distinct.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            rank[i] = '0;
            for (int j = 0; j < NUM_SLOTS; j++) begin
                if ((j != i) && slot_request[j] &&
                    (older[j][i] || (!older[i][j] && (j < i)))) begin
                    rank[i] = rank[i] + RANK_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            ready_rank[p] = '0;
            for (int q = 0; q < p; q++) begin
                if (port_ready[q]) begin
                    ready_rank[p] = ready_rank[p] + CNT_W'(1);
                end
            end
        end
    end

    // The k-th ready port takes the requester whose rank is k.
    always_comb begin
        grant_int = '0;
        valid_int = '0;
        idx_int   = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (port_ready[p] && slot_request[i] && !valid_int[p] &&
                    (rank[i] == RANK_W'(ready_rank[p]))) begin
                    valid_int[p]              = 1'b1;
                    idx_int[p*IDX_W +: IDX_W] = IDX_W'(i);
                    grant_int[i]              = 1'b1;
                end
            end
        end
    end

    always_comb begin
        slot_grant    = '0;
        port_valid    = '0;
        port_slot_idx = '0;
        grant_count   = '0;
        if (reset) begin
            slot_grant    = grant_int;
            port_valid    = valid_int;
            port_slot_idx = idx_int;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                grant_count = grant_count + CNT_W'(grant_int[i]);
            end
        end
    end

endmodule

// File: tb/tb_issue_select_ctrl.sv
// Directed bench for issue_select_ctrl (8 slots, 2 ports) with hand-computed grants.
module tb_issue_select_ctrl;

    logic       clk;
    logic       reset;
    logic       alloc_valid;
    logic [2:0] alloc_idx;
    logic [7:0] slot_request;
    logic [1:0] port_ready;
    logic       flush;
    logic [7:0] slot_grant;
    logic [1:0] port_valid;
    logic [5:0] port_slot_idx;
    logic [1:0] grant_count;

    int compares;
    int mismatches;

    issue_select_ctrl #(.NUM_SLOTS(8), .ISSUE_WIDTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .alloc_valid   (alloc_valid),
        .alloc_idx     (alloc_idx),
        .slot_request  (slot_request),
        .port_ready    (port_ready),
        .flush         (flush),
        .slot_grant    (slot_grant),
        .port_valid    (port_valid),
        .port_slot_idx (port_slot_idx),
        .grant_count   (grant_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compares++;
        if (got !== exp) begin
            mismatches++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change mid-cycle (at negedge) and outputs settle before the check.
    task automatic applyStimulus(input logic av, input logic [2:0] ai, input logic [7:0] req,
                                 input logic [1:0] rdy, input logic fl);
        alloc_valid  = av;
        alloc_idx    = ai;
        slot_request = req;
        port_ready   = rdy;
        flush        = fl;
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkGrant(input string tag, input logic [7:0] g, input logic [1:0] pv,
                              input logic [5:0] idx, input logic [1:0] cnt);
        checkOutput({tag, ".grant"}, 32'(slot_grant), 32'(g));
        checkOutput({tag, ".valid"}, 32'(port_valid), 32'(pv));
        checkOutput({tag, ".idx"},   32'(port_slot_idx), 32'(idx));
        checkOutput({tag, ".count"}, 32'(grant_count), 32'(cnt));
    endtask

    task automatic allocOne(input logic [2:0] idx);
        applyStimulus(1'b1, idx, 8'h00, 2'b11, 1'b0);
        stepCycle();
    endtask

    initial begin
        compares   = 0;
        mismatches = 0;
        reset      = 1'b0;

        // reset held low with everyone requesting
        applyStimulus(1'b0, 3'd0, 8'hFF, 2'b11, 1'b0);
        checkGrant("reset0", 8'h00, 2'b00, 6'o00, 2'd0);
        stepCycle();
        checkGrant("reset1", 8'h00, 2'b00, 6'o00, 2'd0);
        stepCycle();
        reset = 1'b1;
        applyStimulus(1'b0, 3'd0, 8'hFF, 2'b11, 1'b0);
        checkGrant("tie_after_reset", 8'h03, 2'b11, {3'd1, 3'd0}, 2'd2);

        // allocation order 5,2,7
        allocOne(3'd5);
        allocOne(3'd2);
        allocOne(3'd7);
        applyStimulus(1'b0, 3'd0, 8'hA4, 2'b11, 1'b0);
        checkGrant("age_527", 8'h24, 2'b11, {3'd2, 3'd5}, 2'd2);
        stepCycle();
        applyStimulus(1'b0, 3'd0, 8'h80, 2'b11, 1'b0);
        checkGrant("single_req", 8'h80, 2'b01, {3'd0, 3'd7}, 2'd1);
        applyStimulus(1'b0, 3'd0, 8'hA4, 2'b10, 1'b0);
        checkGrant("port0_stall", 8'h20, 2'b10, {3'd5, 3'd0}, 2'd1);
        applyStimulus(1'b0, 3'd0, 8'hFF, 2'b00, 1'b0);
        checkGrant("no_ready", 8'h00, 2'b00, 6'o00, 2'd0);
        stepCycle();
        applyStimulus(1'b0, 3'd0, 8'hA4, 2'b11, 1'b0);
        checkGrant("age_kept", 8'h24, 2'b11, {3'd2, 3'd5}, 2'd2);
        stepCycle();

        // re-allocation of slot 5 makes it youngest
        allocOne(3'd5);
        allocOne(3'd2);
        allocOne(3'd7);
        allocOne(3'd5);
        applyStimulus(1'b0, 3'd0, 8'hA4, 2'b11, 1'b0);
        checkGrant("realloc", 8'h84, 2'b11, {3'd7, 3'd2}, 2'd2);
        stepCycle();

        // same-cycle alloc and request on slot 3
        allocOne(3'd3);
        allocOne(3'd6);
        applyStimulus(1'b1, 3'd3, 8'h48, 2'b01, 1'b0);
        checkGrant("alloc_same_cycle", 8'h08, 2'b01, {3'd0, 3'd3}, 2'd1);
        stepCycle();
        applyStimulus(1'b0, 3'd0, 8'h48, 2'b01, 1'b0);
        checkGrant("alloc_next_cycle", 8'h40, 2'b01, {3'd0, 3'd6}, 2'd1);
        stepCycle();

        // flush: grants still flow in the flush cycle, then ties by index
        allocOne(3'd6);
        allocOne(3'd1);
        applyStimulus(1'b0, 3'd0, 8'h42, 2'b11, 1'b1);
        checkGrant("flush_cycle", 8'h42, 2'b11, {3'd1, 3'd6}, 2'd2);
        stepCycle();
        applyStimulus(1'b0, 3'd0, 8'h42, 2'b11, 1'b0);
        checkGrant("after_flush", 8'h42, 2'b11, {3'd6, 3'd1}, 2'd2);
        stepCycle();

        // flush together with alloc: slot 0 youngest against a cleared matrix
        applyStimulus(1'b1, 3'd0, 8'h00, 2'b11, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 3'd0, 8'h03, 2'b11, 1'b0);
        checkGrant("flush_alloc", 8'h03, 2'b11, {3'd0, 3'd1}, 2'd2);
        stepCycle();

        // reset mid-run clears the age state
        allocOne(3'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 3'd0, 8'h03, 2'b11, 1'b0);
        checkGrant("reset_mid", 8'h00, 2'b00, 6'o00, 2'd0);
        stepCycle();
        reset = 1'b1;
        applyStimulus(1'b0, 3'd0, 8'h03, 2'b11, 1'b0);
        checkGrant("after_reset_mid", 8'h03, 2'b11, {3'd1, 3'd0}, 2'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
